timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Programmable timer controller that sequences a WIDTH-bit up-counter datapath.
- Accepts a start command over a valid/ready handshake and runs the counter from 0 to a programmed limit.
- On reaching the limit it issues a terminal-count tick, then either stops (one-shot) or restarts (periodic).
- Sits between a control/CSR master and any logic that needs timed events.

Parameters:
WIDTH, 4, bit width of the counter and the limit.
PRESCALE, 4, cycles per count step; used only when TIMER_CTRL_PRESCALE_EN is defined; must be >= 1.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_cmd_valid  input  1  start command present.
o_cmd_ready  output  1  controller can accept a command.
i_cmd_limit  input  WIDTH  terminal count value L.
i_cmd_periodic  input  1  1 = auto-restart after terminal count; 0 = one-shot.
i_stop  input  1  abort the current run.
o_count  output  WIDTH  current counter value.
o_busy  output  1  high while in RUN.
o_tick  output  1  one-cycle pulse at terminal count.
o_done  output  1  high while in DONE (one-shot finished).

Behaviour:
- Reset (i_reset=1, asynchronous): state=IDLE, o_count=0, o_tick=0, o_done=0, o_busy=0, limit/periodic registers cleared. o_cmd_ready=1 once reset is released.
- States: IDLE, RUN, DONE. o_busy=(state==RUN). o_cmd_ready=(state!=RUN), combinational from state.
- Command acceptance: a command is accepted on any edge with i_cmd_valid && o_cmd_ready. On acceptance:
  - latch i_cmd_limit into limit_r and i_cmd_periodic into periodic_r;
  - o_count<=0, o_done<=0, o_tick<=0, state<=RUN.
- Valid may be held with ready low; no command is accepted in RUN. Inputs are sampled only at acceptance.
- RUN, per edge, in priority order:
  1. i_stop=1: state<=IDLE, o_count<=0, o_tick<=0, o_done<=0.
  2. o_count==limit_r: o_tick<=1.
     - If periodic_r=1: o_count<=0 and stay in RUN.
     - Else: state<=DONE, o_done<=1, o_count holds limit_r.
  3. Otherwise: o_count<=o_count+1, o_tick<=0.
- Timing:
  - With limit L, o_count reaches L on the L-th RUN edge after acceptance.
  - o_tick is high for the single cycle after the following edge.
  - Tick period in periodic mode = L+1 cycles.
  - L=0 in periodic mode gives o_tick high every cycle. L=0 in one-shot mode ticks once, one edge after acceptance.
- Width and wrap: o_count never exceeds limit_r, so L=2^WIDTH-1 counts to the maximum value without arithmetic overflow. The increment is modulo 2^WIDTH.
- IDLE and DONE:
  - i_stop is ignored and o_tick is 0.
  - o_count holds (0 in IDLE, limit_r in DONE).
  - A new command restarts directly from DONE; o_done drops on the acceptance edge.
- Simultaneous events:
  - i_stop together with terminal count: stop wins, no tick.
  - i_reset asserted mid-run: immediate return to the reset state; no tick is emitted.

Optional Feature:
- Macro: TIMER_CTRL_PRESCALE_EN.
- Defined:
  - An internal prescaler counts 0..PRESCALE-1 while in RUN.
  - RUN steps 2 and 3 (count/terminal) are evaluated only on the edge where the prescaler equals PRESCALE-1; on all other edges o_count holds and o_tick=0.
  - The prescaler resets to 0 on reset, on command acceptance and on i_stop.
  - Tick period becomes (L+1)*PRESCALE cycles.
  - i_stop is still evaluated on every edge.
- Undefined: no prescaler logic; counting occurs every cycle as above.

Test Plan:
- Reset mid-run: accept L=9, assert i_reset after 3 cycles -> o_count=0, o_busy=0, o_tick=0 immediately (asynchronous); o_cmd_ready=1 after release.
- One-shot: accept L=5, periodic=0 -> o_count 0,1,2,3,4,5; single o_tick pulse; o_done=1, o_count=5 holds; o_cmd_ready=1.
- Periodic: accept L=3, periodic=1 -> o_tick pulses every 4 cycles, 5 consecutive times; o_count sequence 0..3 repeating; o_done stays 0.
- Handshake and stop: hold valid during RUN -> no acceptance (limit unchanged). Assert i_stop in the same cycle as count==limit -> IDLE, o_count=0, no tick.
- Boundary limits: L=15 (WIDTH=4) one-shot -> counts to 15, ticks once, no wrap. L=0 periodic -> o_tick high every cycle.
- With TIMER_CTRL_PRESCALE_EN, PRESCALE=4, L=2 periodic -> tick period 12 cycles; o_count steps every 4 cycles.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Start-command handshake between a control/CSR master and timer_ctrl.
// The master drives the command fields; the timer returns ready.
interface timer_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             i_cmd_valid;
   logic             o_cmd_ready;
   logic [WIDTH-1:0] i_cmd_limit;
   logic             i_cmd_periodic;

   modport master (
      output i_cmd_valid,
      output i_cmd_limit,
      output i_cmd_periodic,
      input  o_cmd_ready
   );

   modport slave (
      input  i_cmd_valid,
      input  i_cmd_limit,
      input  i_cmd_periodic,
      output o_cmd_ready
   );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable one-shot/periodic timer: counts 0..limit and pulses o_tick at terminal count.
// Optional count prescaler is enabled by defining TIMER_CTRL_PRESCALE_EN.
module timer_ctrl #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   timer_ctrl_if.slave      cmd,
   input  logic             i_stop,
   output logic [WIDTH-1:0] o_count,
   output logic             o_busy,
   output logic             o_tick,
   output logic             o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r, state_nxt;
   logic [WIDTH-1:0] limit_r, limit_nxt;
   logic             periodic_r, periodic_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             tick_nxt, done_nxt;
   logic             accept;
   logic             step;

`ifdef TIMER_CTRL_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_r, presc_nxt;

   assign step = (presc_r == PRESCALE_LAST);
`else
   // A legal PRESCALE is >= 1; without the prescaler every RUN edge is a count step.
   localparam logic PRESCALE_OK = (PRESCALE >= 1);

   assign step = PRESCALE_OK;
`endif

   assign o_busy          = (state_r == RUN);
   assign cmd.o_cmd_ready = (state_r != RUN);
   assign accept          = cmd.i_cmd_valid && cmd.o_cmd_ready;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state_r;
      count_nxt    = o_count;
      tick_nxt     = 1'b0;
      done_nxt     = o_done;
      limit_nxt    = limit_r;
      periodic_nxt = periodic_r;
`ifdef TIMER_CTRL_PRESCALE_EN
      presc_nxt    = presc_r;
`endif

      unique case (state_r)
         RUN: begin
            if (i_stop) begin
               state_nxt = IDLE;
               count_nxt = '0;
               done_nxt  = 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
               presc_nxt = '0;
`endif
            end else begin
`ifdef TIMER_CTRL_PRESCALE_EN
               presc_nxt = step ? '0 : presc_r + PW'(1);
`endif
               if (step) begin
                  if (o_count == limit_r) begin
                     tick_nxt = 1'b1;
                     if (periodic_r) begin
                        count_nxt = '0;
                     end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                     end
                  end else begin
                     count_nxt = o_count + WIDTH'(1);
                  end
               end
            end
         end

         default: begin
            // IDLE and DONE behave alike: stop is ignored and a command restarts the run.
            if (accept) begin
               state_nxt    = RUN;
               count_nxt    = '0;
               done_nxt     = 1'b0;
               limit_nxt    = cmd.i_cmd_limit;
               periodic_nxt = cmd.i_cmd_periodic;
`ifdef TIMER_CTRL_PRESCALE_EN
               presc_nxt    = '0;
`endif
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r    <= IDLE;
         o_count    <= '0;
         o_tick     <= 1'b0;
         o_done     <= 1'b0;
         limit_r    <= '0;
         periodic_r <= 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
         presc_r    <= '0;
`endif
      end else begin
         state_r    <= state_nxt;
         o_count    <= count_nxt;
         o_tick     <= tick_nxt;
         o_done     <= done_nxt;
         limit_r    <= limit_nxt;
         periodic_r <= periodic_nxt;
`ifdef TIMER_CTRL_PRESCALE_EN
         presc_r    <= presc_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl; observed vector is {count,tick,busy,done,ready}.
// Build with TIMER_CTRL_PRESCALE_EN defined to exercise the prescaler scenario instead.
module tb_timer_ctrl;
   localparam int WIDTH    = 4;
   localparam int PRESCALE = 4;

   logic             i_clk = 1'b0;
   logic             i_reset;
   logic             i_stop;
   logic [WIDTH-1:0] o_count;
   logic             o_busy;
   logic             o_tick;
   logic             o_done;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH+3:0] obs;
   logic [WIDTH+3:0] exp_v;

   timer_ctrl_if #(.WIDTH(WIDTH)) cmd_if ();

   timer_ctrl #(
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .cmd     (cmd_if),
      .i_stop  (i_stop),
      .o_count (o_count),
      .o_busy  (o_busy),
      .o_tick  (o_tick),
      .o_done  (o_done)
   );

   always #5 i_clk = ~i_clk;

   assign obs = {o_count, o_tick, o_busy, o_done, cmd_if.o_cmd_ready};

   // Presents a command for exactly one rising edge; returns on the negedge after acceptance.
   task automatic send_cmd(input logic [WIDTH-1:0] lim, input logic per);
      cmd_if.i_cmd_valid    = 1'b1;
      cmd_if.i_cmd_limit    = lim;
      cmd_if.i_cmd_periodic = per;
      @(negedge i_clk);
      cmd_if.i_cmd_valid    = 1'b0;
   endtask

   task automatic test_reset;
      i_reset               = 1'b1;
      i_stop                = 1'b0;
      cmd_if.i_cmd_valid    = 1'b0;
      cmd_if.i_cmd_limit    = '0;
      cmd_if.i_cmd_periodic = 1'b0;
      repeat (2) @(negedge i_clk);
      exp_v = {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL reset_held: got %b want %b", obs, exp_v);
      end
      i_reset = 1'b0;
      @(negedge i_clk);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL reset_release: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_reset_mid_run;
      send_cmd(WIDTH'(9), 1'b0);
      repeat (3) @(negedge i_clk);
      exp_v = {WIDTH'(3), 1'b0, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL reset_mid_run_pre: got %b want %b", obs, exp_v);
      end
      i_reset = 1'b1;
      #1;
      exp_v = {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL reset_mid_run_async: got %b want %b", obs, exp_v);
      end
      @(negedge i_clk);
      i_reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_mid_run_after[%0d]: got %b want %b", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_oneshot;
      send_cmd(WIDTH'(5), 1'b0);
      for (int c = 0; c <= 5; c++) begin
         exp_v = {WIDTH'(c), 1'b0, 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL oneshot_count[%0d]: got %b want %b", c, obs, exp_v);
         end
         @(negedge i_clk);
      end
      exp_v = {WIDTH'(5), 1'b1, 1'b0, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL oneshot_tick: got %b want %b", obs, exp_v);
      end
      exp_v = {WIDTH'(5), 1'b0, 1'b0, 1'b1, 1'b1};
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL oneshot_done_hold[%0d]: got %b want %b", c, obs, exp_v);
         end
      end
   endtask

   // Restart straight from DONE with L=0 one-shot: done drops, then a single tick one edge later.
   task automatic test_restart_zero_oneshot;
      send_cmd(WIDTH'(0), 1'b0);
      exp_v = {WIDTH'(0), 1'b0, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL restart_accept: got %b want %b", obs, exp_v);
      end
      @(negedge i_clk);
      exp_v = {WIDTH'(0), 1'b1, 1'b0, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL zero_oneshot_tick: got %b want %b", obs, exp_v);
      end
      @(negedge i_clk);
      exp_v = {WIDTH'(0), 1'b0, 1'b0, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL zero_oneshot_after: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_periodic;
      int ticks;
      ticks = 0;
      send_cmd(WIDTH'(3), 1'b1);
      for (int c = 0; c <= 20; c++) begin
         exp_v = {WIDTH'(c % 4), (c > 0) && (c % 4 == 0), 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL periodic[%0d]: got %b want %b", c, obs, exp_v);
         end
         if (o_tick === 1'b1) ticks++;
         @(negedge i_clk);
      end
      n_cmp++;
      if (ticks !== 5) begin
         n_err++;
         $display("FAIL periodic_tick_count: got %0d want 5", ticks);
      end
      i_stop = 1'b1;
      @(negedge i_clk);
      i_stop = 1'b0;
      exp_v = {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL periodic_stop: got %b want %b", obs, exp_v);
      end
   endtask

   // Valid held through RUN with a different command must not replace the running one.
   task automatic test_handshake;
      send_cmd(WIDTH'(7), 1'b0);
      cmd_if.i_cmd_valid    = 1'b1;
      cmd_if.i_cmd_limit    = WIDTH'(2);
      cmd_if.i_cmd_periodic = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         exp_v = {WIDTH'(c), 1'b0, 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL handshake_hold[%0d]: got %b want %b", c, obs, exp_v);
         end
         @(negedge i_clk);
      end
      cmd_if.i_cmd_valid = 1'b0;
      exp_v = {WIDTH'(7), 1'b0, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL handshake_limit_kept: got %b want %b", obs, exp_v);
      end
      @(negedge i_clk);
      exp_v = {WIDTH'(7), 1'b1, 1'b0, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL handshake_terminal: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_stop_at_terminal;
      send_cmd(WIDTH'(2), 1'b0);
      repeat (2) @(negedge i_clk);
      exp_v = {WIDTH'(2), 1'b0, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL stop_pre: got %b want %b", obs, exp_v);
      end
      i_stop = 1'b1;
      exp_v = {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 2; c++) begin
         @(negedge i_clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL stop_at_terminal[%0d]: got %b want %b", c, obs, exp_v);
         end
      end
      i_stop = 1'b0;
   endtask

   task automatic test_max_limit;
      send_cmd(WIDTH'(15), 1'b0);
      for (int c = 0; c <= 15; c++) begin
         exp_v = {WIDTH'(c), 1'b0, 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL max_limit_count[%0d]: got %b want %b", c, obs, exp_v);
         end
         @(negedge i_clk);
      end
      exp_v = {WIDTH'(15), 1'b1, 1'b0, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL max_limit_tick: got %b want %b", obs, exp_v);
      end
      @(negedge i_clk);
      exp_v = {WIDTH'(15), 1'b0, 1'b0, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL max_limit_no_wrap: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_zero_periodic;
      send_cmd(WIDTH'(0), 1'b1);
      exp_v = {WIDTH'(0), 1'b0, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL zero_periodic_accept: got %b want %b", obs, exp_v);
      end
      exp_v = {WIDTH'(0), 1'b1, 1'b1, 1'b0, 1'b0};
      for (int c = 1; c <= 6; c++) begin
         @(negedge i_clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL zero_periodic[%0d]: got %b want %b", c, obs, exp_v);
         end
      end
      i_stop = 1'b1;
      @(negedge i_clk);
      i_stop = 1'b0;
      exp_v = {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL zero_periodic_stop: got %b want %b", obs, exp_v);
      end
   endtask

   // PRESCALE=4, L=2 periodic: count steps every 4 edges, tick every 12.
   task automatic test_prescale;
      int ticks;
      ticks = 0;
      send_cmd(WIDTH'(2), 1'b1);
      for (int c = 0; c <= 36; c++) begin
         exp_v = {WIDTH'((c / PRESCALE) % 3), (c > 0) && (c % 12 == 0), 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++;
            $display("FAIL prescale[%0d]: got %b want %b", c, obs, exp_v);
         end
         if (o_tick === 1'b1) ticks++;
         @(negedge i_clk);
      end
      n_cmp++;
      if (ticks !== 3) begin
         n_err++;
         $display("FAIL prescale_tick_count: got %0d want 3", ticks);
      end
      i_stop = 1'b1;
      @(negedge i_clk);
      i_stop = 1'b0;
      exp_v = {WIDTH'(0), 1'b0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL prescale_stop: got %b want %b", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
`ifdef TIMER_CTRL_PRESCALE_EN
      test_prescale();
`else
      test_reset_mid_run();
      test_oneshot();
      test_restart_zero_oneshot();
      test_periodic();
      test_handshake();
      test_stop_at_terminal();
      test_max_limit();
      test_zero_periodic();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
